// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants for the N-to-1 registered multiplexer family.
//   MODE_FIXED / MODE_RR : values of the Mode input
//   DATA_W               : default CPU datapath word width
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   DATA_W     = 16;

endpackage : mux_pkg

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Rotating-priority arbiter. The search for a valid channel starts at ptr
// and wraps around; after a granted transfer ptr moves just past the winner.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (ptr -> 0)
//   valid     in   N per-channel request
//   advance   in   a transfer to the granted channel happens this cycle
//   grant     out  SW index of the first valid channel from ptr
//   any_valid out  at least one channel is requesting
// ---------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  valid,
    input  logic          advance,
    output logic [SW-1:0] grant,
    output logic          any_valid
);

    logic [SW-1:0] ptr;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                grant     = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            // ptr = (grant + 1) mod N, written so non-power-of-two N wraps
            ptr <= (int'(grant) == N - 1) ? '0 : grant + SW'(1);
        end
    end

endmodule : mux_rr_arbiter

// File: rtl/mux_nn1_reg.sv
// ---------------------------------------------------------------------------
// mux_nn1_reg
// N-to-1 registered multiplexer with valid/ready handshaking on every input
// channel and on the output. One output register; loads whenever it is empty
// or being drained, so full throughput is kept with no bubble.
// Optional feature macro: MUX_RR_EN builds the round-robin arbiter and makes
// the Mode input select between fixed (S) and round-robin granting. Without
// it, Mode is ignored and the grant is always S.
// Ports:
//   Clock      in   clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   Hyrje      in   N*WIDTH channel data, channel i at [i*WIDTH +: WIDTH]
//   Valid_in   in   N per-channel valid
//   Ready_in   out  N per-channel accept (at most one bit set)
//   S          in   SW fixed-mode channel select
//   Mode       in   0 fixed select, 1 round-robin (MUX_RR_EN only)
//   Dalja      out  WIDTH registered output word
//   Kanali     out  SW index of the channel that produced Dalja
//   Valid_out  out  output register holds data
//   Ready_out  in   consumer accepts Dalja
// ---------------------------------------------------------------------------
module mux_nn1_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = DATA_W,
    parameter  int N     = 4,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [N*WIDTH-1:0] Hyrje,
    input  logic [N-1:0]     Valid_in,
    output logic [N-1:0]     Ready_in,
    input  logic [SW-1:0]    S,
    input  logic             Mode,
    output logic [WIDTH-1:0] Dalja,
    output logic [SW-1:0]    Kanali,
    output logic             Valid_out,
    input  logic             Ready_out
);

    logic          load_ok;
    logic          gnt_ok;
    logic [SW-1:0] gnt;
    logic          sel_valid;
    logic          xfer;
    logic signed [WIDTH-1:0] sel_data;

    logic signed [WIDTH-1:0] dalja_p1;
    logic [SW-1:0]           kanali_p1;
    logic                    vld_p1;

    assign load_ok = !vld_p1 | Ready_out;

`ifdef MUX_RR_EN
    logic [SW-1:0] rr_grant;
    logic          rr_any;
    logic          rr_mode;

    assign rr_mode = (Mode == MODE_RR);

    mux_rr_arbiter #(.N(N)) u_arb (
        .clk       (Clock),
        .rst_n     (Resetn),
        .valid     (Valid_in),
        .advance   (xfer & rr_mode),
        .grant     (rr_grant),
        .any_valid (rr_any)
    );

    always_comb begin
        if (rr_mode) begin
            gnt    = rr_grant;
            gnt_ok = rr_any;
        end else begin
            gnt    = S;
            gnt_ok = (int'(S) < N);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = Mode;
    assign gnt         = S;
    assign gnt_ok      = (int'(S) < N);
`endif

    // Decode the grant: select data/valid and raise the one matching Ready_in.
    // An out-of-range select matches no channel, so nothing is accepted.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        Ready_in  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SW'(i)) begin
                sel_valid   = Valid_in[i];
                sel_data    = Hyrje[i*WIDTH +: WIDTH];
                Ready_in[i] = load_ok & gnt_ok;
            end
        end
    end

    assign xfer = gnt_ok & load_ok & sel_valid;

    // ---- stage p1: output register ----
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            vld_p1    <= 1'b0;
            dalja_p1  <= '0;
            kanali_p1 <= '0;
        end else if (xfer) begin
            vld_p1    <= 1'b1;
            dalja_p1  <= sel_data;
            kanali_p1 <= gnt;
        end else if (Ready_out) begin
            vld_p1    <= 1'b0;
        end
    end

    assign Dalja     = dalja_p1;
    assign Kanali    = kanali_p1;
    assign Valid_out = vld_p1;

endmodule : mux_nn1_reg
